// File: rtl/logic_pkg.sv
// Shared constants for the logic unit and the blocks that consume its results.
package logic_pkg;
    localparam int LOGIC_W   = 16;
    localparam int SEL_W     = 3;
    localparam int FLAG_W    = 3;
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_PAR  = 2;
endpackage

// File: rtl/logic_result_fifo_if.sv
// Push/pop handshake bundle for the logic result FIFO; slave is the FIFO side.
interface logic_result_fifo_if import logic_pkg::*; #(
    parameter int WIDTH = LOGIC_W
);
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic [WIDTH-1:0] in_result;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] out_sel;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_parity;

    modport master (
        output in_valid, in_sel, in_result, out_ready,
        input  in_ready, out_valid, out_sel, out_result, out_zero, out_neg, out_parity
    );

    modport slave (
        input  in_valid, in_sel, in_result, out_ready,
        output in_ready, out_valid, out_sel, out_result, out_zero, out_neg, out_parity
    );
endinterface

// File: rtl/logic_flags.sv
// Combinational zero/negative/parity flags for a logic or arithmetic result.
module logic_flags import logic_pkg::*; #(
    parameter int WIDTH = LOGIC_W
) (
    input  logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);
    always_comb begin
        flags            = '0;
        flags[FLAG_ZERO] = (result == '0);
        flags[FLAG_NEG]  = result[WIDTH-1];
        flags[FLAG_PAR]  = ^result;
    end
endmodule

// File: rtl/logic_result_fifo.sv
// Result FIFO: stores {sel, result, flags} per push, pops in order, sticky overflow on rejected pushes.
module logic_result_fifo import logic_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int WIDTH = LOGIC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    logic_result_fifo_if.slave      bus,
    input  logic                    clear_ovf,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = SEL_W + WIDTH + FLAG_W;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [FLAG_W-1:0] in_flags;
    logic [ENT_W-1:0]  head;
    logic              not_full, not_empty, push, pop;

    logic_flags #(.WIDTH(WIDTH)) u_flags (
        .result (bus.in_result),
        .flags  (in_flags)
    );

    // Ready and valid come from count_q only, so out_ready never reaches in_ready.
    always_comb begin
        not_full   = (count_q < CNT_W'(DEPTH));
        not_empty  = (count_q != '0);
        push       = bus.in_valid && not_full;
        pop        = not_empty && bus.out_ready;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (bus.in_valid && !not_full) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; stale entries are masked by the empty check below.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_sel, bus.in_result, in_flags};
        end
    end

    always_comb begin
        head           = not_empty ? mem_q[rd_ptr_q] : '0;
        bus.in_ready   = not_full;
        bus.out_valid  = not_empty;
        bus.out_sel    = head[ENT_W-1 -: SEL_W];
        bus.out_result = head[FLAG_W +: WIDTH];
        bus.out_zero   = head[FLAG_ZERO];
        bus.out_neg    = head[FLAG_NEG];
        bus.out_parity = head[FLAG_PAR];
        count          = count_q;
        overflow       = overflow_q;
    end
endmodule

// File: tb/tb_logic_result_fifo.sv
// Randomized and directed bench for logic_result_fifo with a queue-based reference model.
module tb_logic_result_fifo;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] res;
    } entry_t;

    logic       clk;
    logic       rst_n;
    logic       clear_ovf;
    logic [2:0] count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    entry_t mq[$];
    logic   m_ovf = 1'b0;

    logic_result_fifo_if #(.WIDTH(WIDTH)) bus ();

    logic_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clear_ovf (clear_ovf),
        .count     (count),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is the queue length, flags come from the spec rules.
    initial begin
        int n;
        entry_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_ovf = 1'b0;
                if (!clk) begin
                    chk("rst_count", count, 0);
                    chk("rst_out_valid", bus.out_valid, 0);
                    chk("rst_overflow", overflow, 0);
                end
            end else begin
                n = mq.size();
                chk("count", count, n);
                chk("in_ready", bus.in_ready, n < DEPTH);
                chk("out_valid", bus.out_valid, n != 0);
                chk("overflow", overflow, m_ovf);
                if (n != 0) begin
                    e = mq[0];
                    chk("out_sel", bus.out_sel, e.sel);
                    chk("out_result", bus.out_result, e.res);
                    chk("out_zero", bus.out_zero, e.res == 16'd0);
                    chk("out_neg", bus.out_neg, e.res >= 16'h8000);
                    chk("out_parity", bus.out_parity, $countones(e.res) % 2);
                end else begin
                    chk("empty_data", {bus.out_sel, bus.out_result, bus.out_zero,
                                       bus.out_neg, bus.out_parity}, 0);
                end
                if (n != 0 && bus.out_ready) void'(mq.pop_front());
                if (bus.in_valid && n < DEPTH) begin
                    e.sel = bus.in_sel;
                    e.res = bus.in_result;
                    mq.push_back(e);
                end
                if (bus.in_valid && n == DEPTH) m_ovf = 1'b1;
                else if (clear_ovf) m_ovf = 1'b0;
            end
        end
    end

    task automatic step(input logic v, input logic [2:0] s, input logic [15:0] r,
                        input logic ordy, input logic clr);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_result = r;
        bus.out_ready = ordy;
        clear_ovf     = clr;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vals [4];
        vals[0] = 16'h8001; vals[1] = 16'h00FF; vals[2] = 16'h0001; vals[3] = 16'h7FFF;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_result = '0;
        bus.out_ready = 1'b0;
        clear_ovf     = 1'b0;
        #22 rst_n = 1'b1;

        // Single zero push with consumer stalled.
        step(1'b1, 3'b010, 16'h0000, 1'b0, 1'b0);
        idle();
        chk("s1_count", count, 1);
        chk("s1_zero", bus.out_zero, 1);
        chk("s1_neg_par", {bus.out_neg, bus.out_parity}, 0);
        step(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);

        // Fill to full, reject one push, clear overflow, drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, 3'(i), vals[i], 1'b0, 1'b0);
        idle();
        chk("full_count", count, 4);
        chk("full_in_ready", bus.in_ready, 0);
        step(1'b1, 3'd5, 16'hDEAD, 1'b0, 1'b0);
        idle();
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 4);
        step(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
        idle();
        chk("ovf_clear", overflow, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        idle();

        // Streaming push/pop across two pointer wraps.
        for (int i = 1; i <= 10; i++) step(1'b1, 3'(i), 16'(i), 1'b1, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        idle();
        chk("stream_empty", count, 0);

        // Asynchronous reset mid-cycle with three entries held.
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 16'h1111 * 16'(i + 1), 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_result", bus.out_result, 0);
        #1 rst_n = 1'b1;
        step(1'b1, 3'd6, 16'h4242, 1'b0, 1'b0);
        idle();
        chk("post_rst_push", count, 1);

        // Overflow set wins over a simultaneous clear.
        for (int i = 0; i < 3; i++) step(1'b1, 3'd3, 16'h0F0F, 1'b0, 1'b0);
        step(1'b1, 3'd7, 16'hBEEF, 1'b0, 1'b0);
        step(1'b1, 3'd7, 16'hBEEF, 1'b0, 1'b1);
        idle();
        chk("ovf_set_wins", overflow, 1);
        step(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
        idle();
        chk("ovf_clear2", overflow, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            case ($urandom_range(0, 3))
                0: r = 16'h0000;
                1: r = 16'h8000 | 16'($urandom);
                default: r = 16'($urandom);
            endcase
            step(1'($urandom_range(0, 99) < 60), 3'($urandom), r,
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 10));
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/logic_result_fifo.md
LOGIC_RESULT_FIFO -- requirements
Module: logic_result_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries; SHALL be a power of two and at least 2.
REQ-002 Parameter: WIDTH, 16, result width; SHALL match the logic unit result width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  logic-unit result presented.
REQ-006 Port: in_ready  output  1  FIFO can accept a result this cycle.
REQ-007 Port: in_sel  input  3  operation select that produced the result.
REQ-008 Port: in_result  input  WIDTH  logic-unit result.
REQ-009 Port: out_valid  output  1  head entry available.
REQ-010 Port: out_ready  input  1  consumer accepts the head entry.
REQ-011 Port: out_sel  output  3  select stored with the head entry.
REQ-012 Port: out_result  output  WIDTH  head result.
REQ-013 Port: out_zero / out_neg / out_parity  output  1 each  head flags.
REQ-014 Port: count  output  clog2(DEPTH)+1  current occupancy.
REQ-015 Port: overflow  output  1  sticky flag for a rejected push.
REQ-016 Port: clear_ovf  input  1  synchronous clear of overflow.

Function
REQ-017 A push SHALL occur on a rising edge where in_valid && in_ready.
- The write side SHALL store {in_sel, in_result, flags} at wr_ptr.
- wr_ptr SHALL then advance mod DEPTH.
REQ-018 A pop SHALL occur on a rising edge where out_valid && out_ready; rd_ptr SHALL then advance mod DEPTH.
REQ-019 Flags SHALL be computed at push time as follows:
- zero = (in_result == 0).
- neg = in_result[WIDTH-1].
- parity = XOR-reduction of in_result.
REQ-020 in_ready SHALL equal (count < DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (count != 0).
- out_* data SHALL be driven from the head entry.
- out_* data SHALL be all-zero when empty.
REQ-022 Latency: a result pushed at edge N SHALL appear with out_valid=1 after edge N.
- There is no same-cycle bypass.
REQ-023 count update per edge:
- Push only: count SHALL be +1.
- Pop only: count SHALL be -1.
- Push and pop together: count SHALL be unchanged, and both pointers SHALL advance.
REQ-024 Full: push and pop in the same cycle SHALL be impossible, because in_ready=0; the pop alone SHALL proceed.
REQ-025 Empty: out_ready SHALL be ignored, and pointers and count SHALL remain unchanged.
REQ-026 Ordering: entries SHALL leave strictly in push order across pointer wrap-around.
REQ-027 overflow SHALL set on any edge where in_valid=1 && in_ready=0.
- The rejected data SHALL NOT be stored.
- overflow SHALL clear on an edge with clear_ovf=1, but if a set and clear_ovf occur on the same edge, set SHALL win.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force:
- rd_ptr = wr_ptr = 0.
- count = 0.
- overflow = 0.
- out_valid = 0, with out_* data all-zero.
REQ-029 Reset mid-operation SHALL discard all stored entries.
- Storage contents need not be cleared, but SHALL never be visible while count=0.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 and the first push SHALL be accepted on the next edge.

Structure
REQ-031 Constants SHALL live in the shared package logic_pkg:
- LOGIC_W=16.
- SEL_W=3.
- Flag bit indices (ZERO=0, NEG=1, PAR=2).
REQ-032 Flag generation SHALL be a combinational sub-module logic_flags (result in, 3 flags out), reusable by the arithmetic unit.
REQ-033 Storage SHALL be a register array of DEPTH entries of width SEL_W+WIDTH+3, with no memory macros.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Reset then a single push of sel=010, result=0x0000, with out_ready=0 -> next cycle: out_valid=1, out_zero=1, out_neg=0, out_parity=0, count=1.
- Push 0x8001, 0x00FF, 0x0001, 0x7FFF -> count=4 and in_ready=0; the parity sequence 0,0,1,1 and the neg sequence 1,0,0,0 are popped in order.
- Full FIFO with in_valid=1 held one cycle -> overflow=1, count stays 4, the rejected data never appears at the output; clear_ovf=1 -> overflow=0 on the next edge.
- Continuous push and pop with out_ready=1 for 10 results 0x0001..0x000A -> count stays 1, outputs emerge in order across two pointer wraps.
- rst_n pulsed low mid-cycle with 3 entries stored -> out_valid=0 and count=0 immediately, before any clk edge.
- clear_ovf=1 on the same edge as a new rejected push -> overflow remains 1.
